// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master, one-slave Wishbone classic arbiter.
// Master 0 (instruction bus) and master 1 (data bus) share one slave.
// Grants are round-robin and carry lock semantics: a grant holds for as long
// as the granted master keeps cyc high. Every hand-over passes through IDLE.
// A stall watchdog turns a hung slave into a one-cycle error for the master.
module wb_rr_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255   // legal range 1..65535
) (
   input  logic            wb_clk,
   input  logic            wb_rst_n,
   // master 0
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_we_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   // master 1
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_we_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   // slave
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_we_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   // one-hot grant {m1,m0}; 00 = idle
   output logic [1:0]      grant_o
);

   // State encoding doubles as the one-hot grant vector.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] G0   = 2'b01;
   localparam logic [1:0] G1   = 2'b10;

   logic [1:0]  state, state_nx;
   logic        last, last_nx;      // master that owned the bus most recently
   logic [15:0] tmo_cnt;
   logic        tmo_hit;
   logic        g0, g1;

   assign g0 = (state == G0);
   assign g1 = (state == G1);

   // Next grant: round-robin on a tie, hold while the owner keeps cyc high.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the case leaves it unassigned and infers a latch.
      state_nx = state;
      last_nx  = last;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_nx = last ? G0 : G1;
            else if (m0_cyc_i)        state_nx = G0;
            else if (m1_cyc_i)        state_nx = G1;
         end
         G0: if (!m0_cyc_i) begin
            state_nx = IDLE;
            last_nx  = 1'b0;
         end
         G1: if (!m1_cyc_i) begin
            state_nx = IDLE;
            last_nx  = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Grant state and round-robin history; last=1 lets m0 win the first tie.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      // NOTE: registers are written with non-blocking assignments so every
      // flop samples values from before the edge, independent of block order.
      if (!wb_rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nx;
         last  <= last_nx;
      end
   end

   // Forward path: the granted master drives the slave; IDLE drives all zeros.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      if (g0) begin
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
         s_sel_o = m0_sel_i;
         s_we_o  = m0_we_i;
         s_cyc_o = m0_cyc_i;
         s_stb_o = m0_stb_i;
      end else if (g1) begin
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_sel_o = m1_sel_i;
         s_we_o  = m1_we_i;
         s_cyc_o = m1_cyc_i;
         s_stb_o = m1_stb_i;
      end
   end

   // Watchdog fires while the stall count sits at the limit and a strobe is live.
   assign tmo_hit = (tmo_cnt == 16'(TIMEOUT)) & s_stb_o;

   // Stall counter: counts unanswered strobe cycles, restarts on any completion.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n)
         tmo_cnt <= '0;
      else if ((state == IDLE) || s_ack_i || s_err_i || tmo_hit)
         tmo_cnt <= '0;
      else if (s_cyc_o && s_stb_o)
         tmo_cnt <= tmo_cnt + 16'd1;
   end

   // Return path: only the granted master ever sees ack or err.
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = s_ack_i & g0;
   assign m1_ack_o = s_ack_i & g1;
   assign m0_err_o = (s_err_i | tmo_hit) & g0;
   assign m1_err_o = (s_err_i | tmo_hit) & g1;
   assign grant_o  = state;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed self-checking bench for wb_rr_arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_wb_rr_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [DW-1:0] RD_DATA = 32'hCAFE_F00D;

   logic            wb_clk, wb_rst_n;
   logic [AW-1:0]   m0_adr_i, m1_adr_i, s_adr_o;
   logic [DW-1:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
   logic            m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
   logic            m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
   logic            s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
   logic [1:0]      grant_o;

   // Slave: either acks every live strobe at once, or is driven by hand.
   logic auto_ack, man_ack;
   assign s_ack_i = auto_ack ? (s_cyc_o & s_stb_o) : man_ack;
   assign s_dat_i = RD_DATA;

   int passed = 0;
   int total  = 0;

   wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_err_i(s_err_i), .grant_o(grant_o)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   task automatic clear_inputs();
      m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      s_err_i = 0; auto_ack = 0; man_ack = 0;
   endtask

   task automatic reset_dut();
      wb_rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge wb_clk);
      wb_rst_n = 1'b1;
   endtask

   // Reset state: outputs zero even with busy-looking inputs and a stray ack.
   task automatic test_reset();
      wb_rst_n = 1'b0;
      clear_inputs();
      m0_adr_i = 32'h1234_5678; m1_dat_i = 32'h5555_AAAA; man_ack = 1;
      repeat (2) @(negedge wb_clk);
      total++; if (grant_o !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant_o); else passed++;
      total++; if (s_adr_o !== '0) $display("FAIL reset_s_adr: got %h want 0", s_adr_o); else passed++;
      total++; if (s_dat_o !== '0) $display("FAIL reset_s_dat: got %h want 0", s_dat_o); else passed++;
      total++; if (m0_ack_o !== 1'b0) $display("FAIL reset_m0_ack: got %b want 0", m0_ack_o); else passed++;
      wb_rst_n = 1'b1;
      clear_inputs();
      @(negedge wb_clk);
      total++; if (s_cyc_o !== 1'b0) $display("FAIL reset_s_cyc: got %b want 0", s_cyc_o); else passed++;
   endtask

   // Single m0 read; slave acks on the 2nd strobe cycle.
   task automatic test_single_read();
      reset_dut();
      @(posedge wb_clk); #1;
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0040; m0_sel_i = 4'hF;
      @(negedge wb_clk);
      total++; if (grant_o !== 2'b00) $display("FAIL read_latency: got %b want 00", grant_o); else passed++;
      @(posedge wb_clk); #1;
      @(negedge wb_clk);
      total++; if (grant_o !== 2'b01) $display("FAIL read_grant: got %b want 01", grant_o); else passed++;
      total++; if (s_adr_o !== 32'h40) $display("FAIL read_s_adr: got %h want 40", s_adr_o); else passed++;
      total++; if (m0_ack_o !== 1'b0) $display("FAIL read_early_ack: got %b want 0", m0_ack_o); else passed++;
      @(posedge wb_clk); #1;
      man_ack = 1;
      @(negedge wb_clk);
      total++; if (m0_ack_o !== 1'b1) $display("FAIL read_m0_ack: got %b want 1", m0_ack_o); else passed++;
      total++; if (m1_ack_o !== 1'b0) $display("FAIL read_m1_ack: got %b want 0", m1_ack_o); else passed++;
      total++; if (m0_dat_o !== RD_DATA) $display("FAIL read_m0_dat: got %h want %h", m0_dat_o, RD_DATA); else passed++;
      @(posedge wb_clk); #1;
      man_ack = 0; m0_cyc_i = 0; m0_stb_i = 0;
      @(negedge wb_clk);
      total++; if (m0_ack_o !== 1'b0) $display("FAIL read_ack_one_cycle: got %b want 0", m0_ack_o); else passed++;
      @(posedge wb_clk); #1;
      @(negedge wb_clk);
      total++; if (grant_o !== 2'b00) $display("FAIL read_release: got %b want 00", grant_o); else passed++;
   endtask

   // Both masters rise together after reset, each holds 3 grant cycles.
   task automatic test_tie();
      bit         m0_tab[9]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
      bit         m1_tab[9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
      logic [1:0] exp_g[9]   = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
      reset_dut();
      for (int k = 0; k < 9; k++) begin
         @(posedge wb_clk); #1;
         m0_cyc_i = m0_tab[k]; m0_stb_i = m0_tab[k];
         m1_cyc_i = m1_tab[k]; m1_stb_i = m1_tab[k];
         @(negedge wb_clk);
         total++;
         if (grant_o !== exp_g[k]) $display("FAIL tie_grant[%0d]: got %b want %b", k, grant_o, exp_g[k]);
         else passed++;
      end
   endtask

   // Both masters request continuously; each drops cyc for one cycle after its ack.
   task automatic test_back_to_back();
      bit         m0_tab[13] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
      bit         m1_tab[13] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1};
      logic [1:0] exp_g[13]  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                                 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
      bit         exp_a0[13] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      bit         exp_a1[13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
      reset_dut();
      auto_ack = 1;
      for (int k = 0; k < 13; k++) begin
         @(posedge wb_clk); #1;
         m0_cyc_i = m0_tab[k]; m0_stb_i = m0_tab[k];
         m1_cyc_i = m1_tab[k]; m1_stb_i = m1_tab[k];
         @(negedge wb_clk);
         total++;
         if (grant_o !== exp_g[k]) $display("FAIL b2b_grant[%0d]: got %b want %b", k, grant_o, exp_g[k]);
         else passed++;
         total++;
         if ({m1_ack_o, m0_ack_o} !== {exp_a1[k], exp_a0[k]})
            $display("FAIL b2b_ack[%0d]: got %b%b want %b%b", k, m1_ack_o, m0_ack_o, exp_a1[k], exp_a0[k]);
         else passed++;
      end
      auto_ack = 0;
   endtask

   // TIMEOUT=4, slave never acks: m1_err_o pulses once on the 5th stalled cycle.
   task automatic test_timeout();
      reset_dut();
      for (int k = 0; k < 10; k++) begin
         @(posedge wb_clk); #1;
         if (k == 0) begin m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h80; end
         if (k == 6) m1_stb_i = 0;
         if (k == 8) m1_cyc_i = 0;
         @(negedge wb_clk);
         total++;
         if (grant_o !== ((k >= 1 && k <= 8) ? 2'b10 : 2'b00))
            $display("FAIL tmo_grant[%0d]: got %b want %b", k, grant_o, (k >= 1 && k <= 8) ? 2'b10 : 2'b00);
         else passed++;
         total++;
         if (m1_err_o !== (k == 5)) $display("FAIL tmo_err[%0d]: got %b want %b", k, m1_err_o, k == 5);
         else passed++;
         total++;
         if (m0_err_o !== 1'b0) $display("FAIL tmo_m0_err[%0d]: got %b want 0", k, m0_err_o);
         else passed++;
      end
   endtask

   // Reset asserted mid-write in G1 clears outputs at once; m0 then wins a tie.
   task automatic test_async_reset();
      reset_dut();
      @(posedge wb_clk); #1;
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h100; m1_dat_i = 32'hDEAD_BEEF;
      @(posedge wb_clk); #1;
      @(negedge wb_clk);
      total++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b111) $display("FAIL arst_pre_ctl: got %b want 111", {s_cyc_o, s_stb_o, s_we_o}); else passed++;
      total++; if (s_dat_o !== 32'hDEAD_BEEF) $display("FAIL arst_pre_dat: got %h want deadbeef", s_dat_o); else passed++;
      #2 wb_rst_n = 1'b0;
      #1;
      total++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) $display("FAIL arst_ctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); else passed++;
      total++; if (grant_o !== 2'b00) $display("FAIL arst_grant: got %b want 00", grant_o); else passed++;
      clear_inputs();
      @(negedge wb_clk);
      wb_rst_n = 1'b1;
      @(posedge wb_clk); #1;
      m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
      @(posedge wb_clk); #1;
      @(negedge wb_clk);
      total++; if (grant_o !== 2'b01) $display("FAIL arst_tie: got %b want 01", grant_o); else passed++;
   endtask

   // m0 aborts before ack; a late slave ack in IDLE is dropped; pending m1 follows.
   task automatic test_abort();
      reset_dut();
      @(posedge wb_clk); #1;
      m0_cyc_i = 1; m0_stb_i = 1;
      @(posedge wb_clk); #1;
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
      @(negedge wb_clk);
      total++; if (grant_o !== 2'b01) $display("FAIL abort_grant: got %b want 01", grant_o); else passed++;
      @(posedge wb_clk); #1;
      man_ack = 1;
      @(negedge wb_clk);
      total++; if (grant_o !== 2'b00) $display("FAIL abort_idle: got %b want 00", grant_o); else passed++;
      total++; if ({m1_ack_o, m0_ack_o} !== 2'b00) $display("FAIL abort_late_ack: got %b want 00", {m1_ack_o, m0_ack_o}); else passed++;
      @(posedge wb_clk); #1;
      man_ack = 0;
      @(negedge wb_clk);
      total++; if (grant_o !== 2'b10) $display("FAIL abort_m1_grant: got %b want 10", grant_o); else passed++;
      total++; if (m1_ack_o !== 1'b0) $display("FAIL abort_m1_ack: got %b want 0", m1_ack_o); else passed++;
   endtask

   initial begin
      wb_rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_single_read();
      test_tie();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      test_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
